byte_assembler: RTL and testbench
=================================

# byte_assembler

Serial-to-byte front end that sits directly upstream of the byte-consuming modules. It collects a qualified 1-bit serial stream into `byte_t` words and buffers them in a small FIFO. Complete bytes are presented on a valid/ready interface whose `out_data` port feeds the downstream module's 8-bit `data` input.

## Interface
- `FIFO_DEPTH`, default 4: output buffer depth in bytes; power of two, ≥2.
- `MSB_FIRST`, default 1:
  - 1: the first serial bit of a byte lands in bit 7.
  - 0: the first serial bit lands in bit 0.
- `clk`  in  1: single clock; all logic on its rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `bit_valid`  in  1: `bit_in` is sampled this cycle.
- `bit_in`  in  1: serial data bit.
- `frame_start`  in  1: realign; discards any partial byte.
- `out_valid`  out  1: `out_data` holds a buffered byte.
- `out_ready`  in  1: consumer accepts `out_data` this cycle.
- `out_data`  out  8 (`byte_t`): head-of-FIFO byte.
- `overflow`  out  1: one-cycle pulse; a completed byte was dropped.
- `fill_level`  out  $clog2(FIFO_DEPTH+1): bytes currently buffered.

## Operation
- Collector state machine:
  - IDLE: bit count 0, no partial byte.
  - COLLECT: bit count 1..7.
- Shift register:
  - MSB_FIRST=1: shifts left, new bit enters bit 0.
  - MSB_FIRST=0: shifts right, new bit enters bit 7.
- Counting:
  - Each cycle with `bit_valid`=1 advances the bit count mod 8.
  - The 8th accepted bit completes a byte and returns the collector to IDLE.
- `frame_start`=1 with `bit_valid`=0: count cleared, partial byte discarded, collector → IDLE.
- `frame_start`=1 with `bit_valid`=1: partial byte discarded, and `bit_in` becomes bit 1 of the new byte (collector → COLLECT, count 1).
- Completed byte handling:
  - The byte is pushed into the FIFO at the same edge that samples its 8th bit.
  - If the FIFO is full and no pop occurs that cycle, the byte is dropped and `overflow` pulses high for exactly the following cycle.
- Pop rule: a pop occurs when `out_valid`=1 and `out_ready`=1.
- Simultaneous push and pop is always legal:
  - When full: no drop, `fill_level` stays at FIFO_DEPTH.
  - When empty: the byte is pushed; no pop occurs because `out_valid` was 0.
- Byte ordering is strictly FIFO. `out_data` is stable while `out_valid`=1 and `out_ready`=0.
- `out_data` is don't-care when `out_valid`=0, but it must not produce X after reset.

## Timing
- Reset values: all of the following are 0.
  - Outputs: `out_valid`, `out_data`, `overflow`, `fill_level`.
  - Internal: bit count, shift register, FIFO pointers.
- Reset mid-byte discards the partial byte and all buffered bytes. The first valid bit after `rst_n` rises is bit 1 of a new byte.
- Latency: 8th bit sampled at edge N → `out_valid`=1 (with that byte on `out_data`) in the cycle after edge N, provided the FIFO was empty.
- Throughput: one bit per cycle in; one byte per cycle out.
- `fill_level` updates at the same edge as the push/pop it reflects:
  - +1 for push only.
  - −1 for pop only.
  - Unchanged for both or neither.
- `out_valid` equals `fill_level != 0`, registered. It has no combinational path from `out_ready`.
- `overflow` is registered: high only in the cycle after the dropping edge.

## Structure
- Package `byte_pkg` contains:
  - `typedef logic [7:0] byte_t`.
  - `localparam int BYTE_BITS = 8`.
  - The collector state enum (IDLE, COLLECT).
- Import at module body level.
- Sub-module `byte_fifo`:
  - Parameterised by DEPTH.
  - Synchronous push/pop, show-ahead read, count output.
  - Owns the full/empty and simultaneous push/pop rules.
- `byte_assembler` holds the collector FSM, the shift register and overflow generation.

## Test plan
- MSB_FIRST=1; bits 1,0,1,0,0,1,0,1 on consecutive cycles, `out_ready`=1 → `out_data`=8'hA5 and `out_valid`=1 in the cycle after the 8th bit; `fill_level` returns to 0 next cycle.
- MSB_FIRST=0; bits 0,0,0,1,0,0,1,0 → `out_data`=8'h48; with `out_ready`=0, `out_data` holds 8'h48 for 10 cycles.
- FIFO_DEPTH=4, `out_ready`=0; send bytes 8'h01..8'h05 → `fill_level`=4; `overflow` pulses 1 cycle after the 5th byte completes; draining yields 01,02,03,04 in order.
- FIFO full, `out_ready`=1 in the cycle the next byte completes → no `overflow`, `fill_level` stays 4, popped byte is the oldest.
- 3 bits sent, then `frame_start` without `bit_valid`, then bits for 8'hC3 → only 8'hC3 is emitted.
- 5 bits sent and 2 bytes buffered, then `rst_n` pulsed low mid-cycle → all outputs 0 immediately; after release, 8 bits for 8'h7E → single byte 8'h7E.

Source files
------------

// File: rtl/byte_pkg.sv
// byte_pkg: shared byte type, byte width and collector state encoding
package byte_pkg;
  typedef logic [7:0] byte_t;
  localparam int BYTE_BITS = 8;
  typedef enum logic {IDLE, COLLECT} coll_state_t;
endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: show-ahead byte FIFO that accepts a push into a full buffer only when a pop frees a slot that cycle
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  byte_pkg::byte_t            i_data,
  input  logic                       i_ready,
  output logic                       o_valid,
  output byte_pkg::byte_t            o_data,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_drop
);
  import byte_pkg::*;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  byte_t r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_count;
  logic w_full, w_pop, w_wr;
  assign w_full  = r_count == CW'(DEPTH);
  assign o_valid = r_count != '0;
  assign w_pop   = o_valid & i_ready;
  assign w_wr    = i_push & (!w_full | w_pop);
  assign o_drop  = i_push & w_full & !w_pop;
  assign o_data  = r_mem[r_rd];
  assign o_count = r_count;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_count <= r_count + CW'(w_wr) - CW'(w_pop);
    end
  end
endmodule

// File: rtl/byte_assembler.sv
// byte_assembler: collects a qualified serial bit stream into bytes and buffers them for a valid/ready consumer
module byte_assembler #(
  parameter int FIFO_DEPTH = 4,
  parameter bit MSB_FIRST  = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            bit_valid,
  input  logic                            bit_in,
  input  logic                            frame_start,
  output logic                            out_valid,
  input  logic                            out_ready,
  output byte_pkg::byte_t                 out_data,
  output logic                            overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fill_level
);
  import byte_pkg::*;
  localparam int CNT_W = $clog2(BYTE_BITS);
  coll_state_t r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_base, w_cnt_nxt;
  byte_t r_shift, w_shift_base, w_shift_nxt;
  logic w_push, w_drop, r_overflow;
  always_comb begin
    w_cnt_base   = (frame_start || r_state == IDLE) ? '0 : r_cnt;
    w_shift_base = (frame_start || r_state == IDLE) ? '0 : r_shift;
    w_shift_nxt  = !bit_valid ? w_shift_base :
                   MSB_FIRST  ? {w_shift_base[6:0], bit_in} : {bit_in, w_shift_base[7:1]};
    w_cnt_nxt    = w_cnt_base + CNT_W'(bit_valid);
    w_push       = bit_valid & (w_cnt_base == CNT_W'(BYTE_BITS-1));
    w_state_nxt  = (w_cnt_nxt != '0) ? COLLECT : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_overflow <= w_drop;
    end
  end
  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_shift_nxt),
    .i_ready (out_ready),
    .o_valid (out_valid),
    .o_data  (out_data),
    .o_count (fill_level),
    .o_drop  (w_drop)
  );
  assign overflow = r_overflow;
endmodule

// File: tb/tb_byte_assembler.sv
// tb_byte_assembler: directed checks of an MSB-first and an LSB-first assembler driven by the same stream
module tb_byte_assembler;
  logic clk = 1'b0;
  logic rst_n, bit_valid, bit_in, frame_start, out_ready;
  logic m_valid, m_ovf, l_valid, l_ovf;
  logic [7:0] m_data, l_data;
  logic [2:0] m_fill, l_fill;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  byte_assembler #(.FIFO_DEPTH(4), .MSB_FIRST(1)) dut (
    .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .bit_in(bit_in), .frame_start(frame_start),
    .out_valid(m_valid), .out_ready(out_ready), .out_data(m_data), .overflow(m_ovf), .fill_level(m_fill)
  );
  byte_assembler #(.FIFO_DEPTH(4), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .bit_in(bit_in), .frame_start(frame_start),
    .out_valid(l_valid), .out_ready(out_ready), .out_data(l_data), .overflow(l_ovf), .fill_level(l_fill)
  );
  task automatic send_bit(input logic b);
    bit_valid = 1'b1;
    bit_in    = b;
    @(posedge clk); #1;
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask
  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask
  task automatic test_reset;
    n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b expected 0", m_valid); end
    n_cmp++; if (m_data !== 8'h00) begin n_bad++; $display("FAIL rst_data: got %h expected 00", m_data); end
    n_cmp++; if (m_ovf !== 1'b0) begin n_bad++; $display("FAIL rst_ovf: got %b expected 0", m_ovf); end
    n_cmp++; if (m_fill !== 3'd0) begin n_bad++; $display("FAIL rst_fill: got %0d expected 0", m_fill); end
    n_cmp++; if (l_data !== 8'h00) begin n_bad++; $display("FAIL rst_lsb_data: got %h expected 00", l_data); end
  endtask
  task automatic test_msb_first;
    out_ready = 1'b1;
    send_byte(8'hA5);
    n_cmp++; if (m_valid !== 1'b1) begin n_bad++; $display("FAIL msb_valid: got %b expected 1", m_valid); end
    n_cmp++; if (m_data !== 8'hA5) begin n_bad++; $display("FAIL msb_data: got %h expected a5", m_data); end
    n_cmp++; if (m_fill !== 3'd1) begin n_bad++; $display("FAIL msb_fill: got %0d expected 1", m_fill); end
    @(posedge clk); #1;
    n_cmp++; if (m_fill !== 3'd0) begin n_bad++; $display("FAIL msb_fill_drain: got %0d expected 0", m_fill); end
    n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL msb_valid_drain: got %b expected 0", m_valid); end
    out_ready = 1'b0;
  endtask
  task automatic test_lsb_first;
    send_byte(8'h12);
    n_cmp++; if (l_data !== 8'h48) begin n_bad++; $display("FAIL lsb_data: got %h expected 48", l_data); end
    n_cmp++; if (m_data !== 8'h12) begin n_bad++; $display("FAIL lsb_msb_ref: got %h expected 12", m_data); end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      n_cmp++; if (l_data !== 8'h48 || l_valid !== 1'b1) begin n_bad++; $display("FAIL lsb_hold[%0d]: got %h/%b expected 48/1", c, l_data, l_valid); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++; if (l_fill !== 3'd0) begin n_bad++; $display("FAIL lsb_drain: got %0d expected 0", l_fill); end
  endtask
  task automatic test_overflow;
    for (int v = 1; v <= 4; v++) send_byte(8'(v));
    n_cmp++; if (m_fill !== 3'd4) begin n_bad++; $display("FAIL ovf_fill_full: got %0d expected 4", m_fill); end
    n_cmp++; if (m_ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_early: got %b expected 0", m_ovf); end
    send_byte(8'h05);
    n_cmp++; if (m_ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_pulse: got %b expected 1", m_ovf); end
    n_cmp++; if (m_fill !== 3'd4) begin n_bad++; $display("FAIL ovf_fill: got %0d expected 4", m_fill); end
    @(posedge clk); #1;
    n_cmp++; if (m_ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_one_cycle: got %b expected 0", m_ovf); end
    out_ready = 1'b1;
    for (int v = 1; v <= 4; v++) begin
      n_cmp++; if (m_data !== 8'(v)) begin n_bad++; $display("FAIL ovf_order[%0d]: got %h expected %h", v, m_data, 8'(v)); end
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    n_cmp++; if (m_fill !== 3'd0 || m_valid !== 1'b0) begin n_bad++; $display("FAIL ovf_empty: got %0d/%b expected 0/0", m_fill, m_valid); end
  endtask
  task automatic test_full_pop;
    logic [7:0] v;
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    v = 8'h55;
    for (int i = 7; i >= 1; i--) send_bit(v[i]);
    n_cmp++; if (m_data !== 8'h11) begin n_bad++; $display("FAIL fp_head: got %h expected 11", m_data); end
    out_ready = 1'b1;
    send_bit(v[0]);
    out_ready = 1'b0;
    n_cmp++; if (m_ovf !== 1'b0) begin n_bad++; $display("FAIL fp_no_ovf: got %b expected 0", m_ovf); end
    n_cmp++; if (m_fill !== 3'd4) begin n_bad++; $display("FAIL fp_fill: got %0d expected 4", m_fill); end
    n_cmp++; if (m_data !== 8'h22) begin n_bad++; $display("FAIL fp_next: got %h expected 22", m_data); end
    out_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      n_cmp++; if (m_data !== 8'(k * 8'h11)) begin n_bad++; $display("FAIL fp_order[%0d]: got %h expected %h", k, m_data, 8'(k * 8'h11)); end
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    n_cmp++; if (m_fill !== 3'd0) begin n_bad++; $display("FAIL fp_empty: got %0d expected 0", m_fill); end
  endtask
  task automatic test_frame_start;
    logic [7:0] v;
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    send_byte(8'hC3);
    n_cmp++; if (m_fill !== 3'd1 || m_data !== 8'hC3) begin n_bad++; $display("FAIL fs_byte: got %0d/%h expected 1/c3", m_fill, m_data); end
    @(posedge clk); #1;
    n_cmp++; if (m_fill !== 3'd1) begin n_bad++; $display("FAIL fs_single: got %0d expected 1", m_fill); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    v = 8'h96;
    frame_start = 1'b1;
    send_bit(v[7]);
    frame_start = 1'b0;
    for (int i = 6; i >= 0; i--) send_bit(v[i]);
    n_cmp++; if (m_fill !== 3'd1 || m_data !== 8'h96) begin n_bad++; $display("FAIL fs_with_bit: got %0d/%h expected 1/96", m_fill, m_data); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask
  task automatic test_reset_mid;
    send_byte(8'hAB); send_byte(8'hCD);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    #3 rst_n = 1'b0;
    #1;
    n_cmp++; if (m_valid !== 1'b0 || m_fill !== 3'd0 || m_data !== 8'h00 || m_ovf !== 1'b0) begin n_bad++; $display("FAIL rm_async: got %b/%0d/%h/%b expected 0/0/00/0", m_valid, m_fill, m_data, m_ovf); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    send_byte(8'h7E);
    n_cmp++; if (m_fill !== 3'd1 || m_data !== 8'h7E) begin n_bad++; $display("FAIL rm_byte: got %0d/%h expected 1/7e", m_fill, m_data); end
    @(posedge clk); #1;
    n_cmp++; if (m_fill !== 3'd1) begin n_bad++; $display("FAIL rm_single: got %0d expected 1", m_fill); end
  endtask
  initial begin
    rst_n = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; frame_start = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    test_msb_first;
    test_lsb_first;
    test_overflow;
    test_full_pop;
    test_frame_start;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
